core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
Shares one memory bus between instruction fetch (imem, read-only) and load/store (dmem, read/write). Sits between core_pipe_fetch / the LSU and the memory interconnect. Uses the core's request/grant protocol, with the response returned one cycle after the grant. Selection is data-side priority, with a starvation counter that forces a fetch grant.

Parameters:
STARVE_LIMIT, 4, consecutive cycles fetch may be refused while requesting before fetch is forced to win; legal range 1..15.
CNT_W, 4, width of the starvation counter; must satisfy STARVE_LIMIT < 2**CNT_W.

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
imem_req  in  1  fetch request
imem_addr  in  MEM_ADDR_R+1  fetch address
imem_gnt  out  1  fetch request accepted this cycle
imem_err  out  1  fetch response error
imem_rdata  out  MEM_DATA_R+1  fetch response data
dmem_req  in  1  LSU request
dmem_wen  in  1  LSU write enable
dmem_strb  in  MEM_STRB_R+1  LSU byte strobes
dmem_addr  in  MEM_ADDR_R+1  LSU address
dmem_wdata  in  MEM_DATA_R+1  LSU write data
dmem_gnt  out  1  LSU request accepted
dmem_err  out  1  LSU response error
dmem_rdata  out  MEM_DATA_R+1  LSU response data
mem_req  out  1  bus request
mem_wen  out  1  bus write enable
mem_strb  out  MEM_STRB_R+1  bus strobes
mem_addr  out  MEM_ADDR_R+1  bus address
mem_wdata  out  MEM_DATA_R+1  bus write data
mem_gnt  in  1  bus grant
mem_err  in  1  bus response error, valid the cycle after a grant
mem_rdata  in  MEM_DATA_R+1  bus response data, valid the cycle after a grant

Behaviour:
- Reset: g_resetn is synchronous and active-low; the clock is g_clk.
  - While g_resetn is low, mem_req, imem_gnt and dmem_gnt are 0.
  - Reset clears state to DPRI, starve_cnt to 0 and rsp_valid to 0.
- Requesters may drop a request before it is granted. Arbitration is re-evaluated combinationally every cycle; there is no lock on a refused request.
- Select (combinational):
  - Only one requester active: it is selected.
  - Both active in DPRI: dmem is selected.
  - Both active in IPRI: imem is selected.
- Bus drive:
  - mem_req = imem_req | dmem_req.
  - mem_addr, mem_wen, mem_strb and mem_wdata are muxed from the selected requester.
  - When imem is selected: mem_wen = 0, mem_strb = all ones, mem_wdata = 0.
- Grants: imem_gnt = mem_gnt & sel_i; dmem_gnt = mem_gnt & sel_d. The two grants are never both high.
- Response tracking:
  - On any grant, register rsp_valid = 1 and rsp_owner = selected requester; otherwise rsp_valid = 0.
  - The next cycle, mem_rdata is broadcast to both imem_rdata and dmem_rdata.
  - mem_err is routed only to the owner: imem_err = rsp_valid & owner_i & mem_err, and likewise dmem_err. The non-owner's err is 0.
- Back-to-back grants are allowed; each response is tracked independently, one deep (latency is fixed at 1).
- starve_cnt (CNT_W bits, saturating):
  - Increments when imem_req & !imem_gnt.
  - Clears when imem_gnt or !imem_req.
- State machine DPRI/IPRI:
  - DPRI -> IPRI when the counter reaches STARVE_LIMIT and imem_req is still high.
  - IPRI -> DPRI on imem_gnt, or when imem_req drops.
  - IPRI never starves dmem for more than one fetch grant.
- Simultaneous events: a grant plus a state exit in the same cycle takes effect the next cycle. Counter clear has priority over increment.
- Reset mid-transaction: any pending response is dropped, err outputs are 0 the next cycle, and no grant is issued.
- mem_gnt without mem_req is ignored; no grant is issued.

Decomposition:
- MEM_ADDR_R, MEM_DATA_R and MEM_STRB_R come from core_common.vh.
- Add the state encodings ARB_DPRI/ARB_IPRI and the owner encodings RSP_IMEM/RSP_DMEM there as localparams.
- One sub-module: core_mem_arbiter_starve, containing the counter plus the DPRI/IPRI state register and outputting force_i.

Test Plan:
- imem_req only, imem_addr=0x80000000, mem_gnt=1 -> mem_addr=0x80000000, mem_wen=0, imem_gnt=1; the next cycle mem_rdata=0x1122334455667788 appears on imem_rdata, with imem_err=0 and dmem_err=0.
- Both requesting, dmem write addr=0x1000 strb=0x0F, mem_gnt=1 -> dmem_gnt=1, imem_gnt=0, mem_wen=1, mem_strb=0x0F.
- Both held high with mem_gnt=1 every cycle, STARVE_LIMIT=4 -> dmem granted 4 cycles, imem granted on cycle 5, dmem granted again on cycle 6.
- mem_err=1 the cycle after a dmem grant -> dmem_err=1 and imem_err=0. The same case following an imem grant -> imem_err=1 only.
- imem_req drops after 3 refused cycles -> starve_cnt=0; re-assert gives 4 further dmem-priority cycles before the forced fetch.
- g_resetn low for one cycle directly after a grant -> the next cycle has imem_err=dmem_err=0, no grants during reset, state DPRI and count 0.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared bus widths, arbitration state and response-owner encodings for the
// core memory arbiter.
package core_mem_arbiter_pkg;

    localparam int MEM_ADDR_R = 31;
    localparam int MEM_DATA_R = 63;
    localparam int MEM_STRB_R = 7;

    typedef enum logic {
        ARB_DPRI = 1'b0,
        ARB_IPRI = 1'b1
    } arb_state_t;

    localparam logic RSP_DMEM = 1'b0;
    localparam logic RSP_IMEM = 1'b1;

endpackage

// File: rtl/core_mem_arbiter_starve.sv
// Fetch starvation tracker: counts consecutive refused fetch cycles and
// raises force_i_o while fetch priority is in effect.
module core_mem_arbiter_starve
    import core_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic imem_req_i,
    input  logic imem_gnt_i,
    output logic force_i_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] SAT_C   = {CNT_W{1'b1}};

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and priority state; a clear wins over an increment.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (!imem_req_i || imem_gnt_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != SAT_C) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ARB_DPRI: begin
                if (imem_req_i && !imem_gnt_i && (cnt_d >= LIMIT_C)) begin
                    state_d = ARB_IPRI;
                end else begin
                    state_d = ARB_DPRI;
                end
            end
            ARB_IPRI: begin
                if (imem_gnt_i || !imem_req_i) begin
                    state_d = ARB_DPRI;
                end else begin
                    state_d = ARB_IPRI;
                end
            end
            default: state_d = ARB_DPRI;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ARB_DPRI;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign force_i_o = (state_q == ARB_IPRI);

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, with data
// priority and a starvation override for fetch; responses arrive one cycle after grant.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  imem_req,
    input  logic [MEM_ADDR_R:0]   imem_addr,
    output logic                  imem_gnt,
    output logic                  imem_err,
    output logic [MEM_DATA_R:0]   imem_rdata,
    input  logic                  dmem_req,
    input  logic                  dmem_wen,
    input  logic [MEM_STRB_R:0]   dmem_strb,
    input  logic [MEM_ADDR_R:0]   dmem_addr,
    input  logic [MEM_DATA_R:0]   dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [MEM_DATA_R:0]   dmem_rdata,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [MEM_STRB_R:0]   mem_strb,
    output logic [MEM_ADDR_R:0]   mem_addr,
    output logic [MEM_DATA_R:0]   mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_err,
    input  logic [MEM_DATA_R:0]   mem_rdata
);

    logic force_i;
    logic sel_imem;
    logic sel_dmem;
    logic rsp_valid_q;
    logic rsp_valid_d;
    logic rsp_owner_q;
    logic rsp_owner_d;

    core_mem_arbiter_starve #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .imem_req_i (imem_req),
        .imem_gnt_i (imem_gnt),
        .force_i_o  (force_i)
    );

    // Selection is gated by reset so nothing reaches the bus while held in reset.
    assign sel_imem = g_resetn & imem_req & (~dmem_req | force_i);
    assign sel_dmem = g_resetn & dmem_req & ~sel_imem;

    assign mem_req  = g_resetn & (imem_req | dmem_req);
    assign imem_gnt = mem_gnt & sel_imem;
    assign dmem_gnt = mem_gnt & sel_dmem;

    // Bus field mux; fetch is always a full-width read.
    always_comb begin
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
        if (sel_imem) begin
            mem_addr  = imem_addr;
            mem_wen   = 1'b0;
            mem_strb  = {(MEM_STRB_R+1){1'b1}};
            mem_wdata = {(MEM_DATA_R+1){1'b0}};
        end else begin
            mem_addr  = dmem_addr;
            mem_wen   = dmem_wen;
            mem_strb  = dmem_strb;
            mem_wdata = dmem_wdata;
        end
    end

    // Record who owns the single in-flight response.
    always_comb begin
        rsp_valid_d = imem_gnt | dmem_gnt;
        if (imem_gnt) begin
            rsp_owner_d = RSP_IMEM;
        end else begin
            rsp_owner_d = RSP_DMEM;
        end
    end

    // Response tracking registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= RSP_DMEM;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;
    assign imem_err   = g_resetn & rsp_valid_q & (rsp_owner_q == RSP_IMEM) & mem_err;
    assign dmem_err   = g_resetn & rsp_valid_q & (rsp_owner_q == RSP_DMEM) & mem_err;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized and directed checks of core_mem_arbiter against a behavioural
// model of the request/grant, response routing and fetch starvation rules.
module tb_core_mem_arbiter;

    localparam int LIMIT = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_err;
    logic [63:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_err;
    logic [63:0] dmem_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Model: consecutive refused fetch cycles and the single pending response.
    int run_len;
    bit pend_v;
    bit pend_imem;
    bit last_ignt;
    bit last_dgnt;

    core_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_err(imem_err), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are already driven; check mid-cycle, advance the model, then step past the edge.
    task automatic apply_cycle();
        bit in_rst, fetch_wins, data_wins, e_req, e_ignt, e_dgnt;
        #4;
        in_rst     = !g_resetn;
        fetch_wins = !in_rst && imem_req && (!dmem_req || run_len >= LIMIT);
        data_wins  = !in_rst && dmem_req && !fetch_wins;
        e_req      = !in_rst && (imem_req || dmem_req);
        e_ignt     = fetch_wins && mem_gnt;
        e_dgnt     = data_wins && mem_gnt;
        check_vec("mem_req", {63'd0, mem_req}, {63'd0, e_req});
        check_vec("imem_gnt", {63'd0, imem_gnt}, {63'd0, e_ignt});
        check_vec("dmem_gnt", {63'd0, dmem_gnt}, {63'd0, e_dgnt});
        if (e_req) begin
            check_vec("mem_addr", {32'd0, mem_addr}, {32'd0, fetch_wins ? imem_addr : dmem_addr});
            check_vec("mem_wen", {63'd0, mem_wen}, {63'd0, fetch_wins ? 1'b0 : dmem_wen});
            check_vec("mem_strb", {56'd0, mem_strb}, {56'd0, fetch_wins ? 8'hFF : dmem_strb});
            check_vec("mem_wdata", mem_wdata, fetch_wins ? 64'd0 : dmem_wdata);
        end
        check_vec("imem_rdata", imem_rdata, mem_rdata);
        check_vec("dmem_rdata", dmem_rdata, mem_rdata);
        check_vec("imem_err", {63'd0, imem_err}, {63'd0, !in_rst && pend_v && pend_imem && mem_err});
        check_vec("dmem_err", {63'd0, dmem_err}, {63'd0, !in_rst && pend_v && !pend_imem && mem_err});
        last_ignt = imem_gnt;
        last_dgnt = dmem_gnt;
        if (in_rst) begin
            run_len = 0;
            pend_v  = 1'b0;
        end else begin
            pend_v    = e_ignt || e_dgnt;
            pend_imem = e_ignt;
            run_len   = (imem_req && !e_ignt) ? run_len + 1 : 0;
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_idle();
        g_resetn   = 1'b1;
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        dmem_req   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_strb  = 8'h0;
        dmem_addr  = 32'h0;
        dmem_wdata = 64'h0;
        mem_gnt    = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = 64'h0;
    endtask

    task automatic do_reset();
        set_idle();
        g_resetn = 1'b0;
        apply_cycle();
        g_resetn = 1'b1;
    endtask

    // Both requesters high with the bus granting every cycle; returns the fetch grant pattern.
    task automatic both_high(input int n, output logic [7:0] pat);
        pat = 8'h0;
        for (int k = 0; k < n; k++) begin
            set_idle();
            imem_req  = 1'b1;
            imem_addr = 32'h8000_0000 + 32'(k * 4);
            dmem_req  = 1'b1;
            dmem_addr = 32'h2000 + 32'(k * 8);
            mem_gnt   = 1'b1;
            apply_cycle();
            pat = {pat[6:0], last_ignt};
        end
    endtask

    initial begin
        logic [7:0] pat;
        run_len   = 0;
        pend_v    = 1'b0;
        pend_imem = 1'b0;
        set_idle();
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        do_reset();

        // Fetch alone, then its read data on the following cycle.
        set_idle();
        imem_req  = 1'b1;
        imem_addr = 32'h8000_0000;
        mem_gnt   = 1'b1;
        apply_cycle();
        check_vec("fetch_alone_gnt", {63'd0, last_ignt}, 64'd1);
        set_idle();
        mem_rdata = 64'h1122_3344_5566_7788;
        apply_cycle();
        check_vec("fetch_rdata", imem_rdata, 64'h1122_3344_5566_7788);

        // Store wins over fetch, then an error is routed back to the store.
        set_idle();
        imem_req  = 1'b1;
        dmem_req  = 1'b1;
        dmem_wen  = 1'b1;
        dmem_addr = 32'h1000;
        dmem_strb = 8'h0F;
        mem_gnt   = 1'b1;
        apply_cycle();
        check_vec("store_wins", {62'd0, last_ignt, last_dgnt}, 64'd1);
        set_idle();
        mem_err = 1'b1;
        #4;
        check_vec("store_err_routed", {62'd0, imem_err, dmem_err}, 64'd1);
        apply_cycle();

        // Starvation: four data grants, forced fetch, then data again.
        do_reset();
        both_high(6, pat);
        check_vec("starve_pattern", {56'd0, pat}, 64'h02);
        set_idle();
        mem_err = 1'b1;
        apply_cycle();

        // Fetch drop after three refusals restarts the count.
        do_reset();
        both_high(3, pat);
        set_idle();
        dmem_req = 1'b1;
        mem_gnt  = 1'b1;
        apply_cycle();
        both_high(5, pat);
        check_vec("drop_restart_pattern", {56'd0, pat}, 64'h01);

        // Reset directly after a grant drops the pending response.
        set_idle();
        imem_req = 1'b1;
        mem_gnt  = 1'b1;
        apply_cycle();
        set_idle();
        g_resetn = 1'b0;
        imem_req = 1'b1;
        dmem_req = 1'b1;
        mem_gnt  = 1'b1;
        mem_err  = 1'b1;
        apply_cycle();
        check_vec("rst_no_gnt", {62'd0, last_ignt, last_dgnt}, 64'd0);
        set_idle();
        mem_err = 1'b1;
        #4;
        check_vec("rst_err_dropped", {62'd0, imem_err, dmem_err}, 64'd0);
        apply_cycle();
        both_high(5, pat);
        check_vec("post_rst_pattern", {56'd0, pat}, 64'h01);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            g_resetn   = ($urandom_range(99) >= 2);
            imem_req   = ($urandom_range(99) < 70);
            imem_addr  = $urandom;
            dmem_req   = ($urandom_range(99) < 60);
            dmem_wen   = $urandom_range(1);
            dmem_strb  = 8'($urandom);
            dmem_addr  = $urandom;
            dmem_wdata = {$urandom, $urandom};
            mem_gnt    = ($urandom_range(99) < 75);
            mem_err    = ($urandom_range(99) < 25);
            mem_rdata  = {$urandom, $urandom};
            apply_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
